// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants for the multiply/divide execute unit
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 64;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_SMULH = 3'b001;
  localparam logic [2:0] OP_UMULH = 3'b010;
  localparam logic [2:0] OP_SDIV  = 3'b100;
  localparam logic [2:0] OP_UDIV  = 3'b101;

  // Writes to the zero register are swallowed at the register file port.
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operand request and writeback handshake bundle
interface muldiv_unit_if #(
  parameter int WIDTH = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [4:0]       in_rd;
  logic             out_valid;
  logic             out_ready;
  logic             out_write;
  logic [4:0]       out_rd;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_write, out_rd, out_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_write, out_rd, out_data
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider
// feeding the register file write port with a fixed WIDTH+2 cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic          clock,
  input logic          reset_n,
  input logic          flush,
  muldiv_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] twos_negate(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_q;
  logic             bzero_q;
  // hi_q:lo_q is the 2*WIDTH product, or remainder:dividend/quotient when dividing.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;

  logic             acc_div;
  logic             acc_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;

  assign acc_div    = bus.in_op[2];
  assign acc_signed = (bus.in_op == OP_SMULH) || (bus.in_op == OP_SDIV);
  assign a_neg      = acc_signed & bus.in_a[WIDTH-1];
  assign b_neg      = acc_signed & bus.in_b[WIDTH-1];
  assign a_op       = twos_negate(bus.in_a, a_neg);
  assign b_op       = twos_negate(bus.in_b, b_neg);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  assign mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(WIDTH+1){lo_q[0]}});
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // High half of -(hi:lo): a borrow out of the low half only exists when lo is zero.
  logic [WIDTH-1:0] smulh_hi;
  logic [WIDTH-1:0] result;

  assign smulh_hi = (neg_q && (lo_q != '0)) ? ~hi_q : twos_negate(hi_q, neg_q);

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:   result = lo_q;
      OP_SMULH: result = smulh_hi;
      OP_UMULH: result = hi_q;
      OP_SDIV:  result = bzero_q ? '0 : twos_negate(lo_q, neg_q);
      OP_UDIV:  result = bzero_q ? '0 : lo_q;
      default:  result = '0;
    endcase
  end

  assign bus.in_ready  = reset_n && (state == IDLE);
  assign bus.out_write = bus.out_valid & bus.out_ready & ~flush & (bus.out_rd != XZR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= OP_MUL;
      rd_q          <= '0;
      neg_q         <= 1'b0;
      bzero_q       <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      opnd_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_rd    <= '0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_op;
            rd_q    <= bus.in_rd;
            neg_q   <= a_neg ^ b_neg;
            bzero_q <= (bus.in_b == '0);
            hi_q    <= '0;
            lo_q    <= acc_div ? a_op : b_op;
            opnd_q  <= acc_div ? b_op : a_op;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
              hi_q <= div_diff[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_q <= div_shift[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          bus.out_data  <= result;
          bus.out_rd    <= rd_q;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    int           hold;
    logic [W-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 3'b101;
    bus.in_a     = ~a;
    bus.in_b     = a ^ b ^ 64'h5a;
    bus.in_rd    = ~rd;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   cyc;
    logic ok;
    @(negedge clock);
    check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'(1));
    bus.out_ready = (v.hold == 0);
    start_op(v.op, v.a, v.b, v.rd);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.out_valid && cyc < 200);
    check({tag, " latency"}, 64'(cyc), 64'(66));
    check({tag, " data"}, bus.out_data, v.exp);
    check({tag, " rd"}, 64'(bus.out_rd), 64'(v.rd));
    ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== v.exp || bus.out_rd !== v.rd ||
          bus.in_ready !== 1'b0 || bus.out_write !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    if (v.hold > 0) check({tag, " hold stable"}, 64'(ok), 64'(1));
    bus.out_ready = 1'b1;
    #1;
    check({tag, " write"}, 64'(bus.out_write), 64'(v.rd != 5'd31));
    @(negedge clock);
    check({tag, " valid drop"}, 64'(bus.out_valid), 64'(0));
    check({tag, " ready back"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int   cyc;
    logic seen_valid;
    logic seen_write;

    vecs[0]  = '{OP_MUL,   64'h7, 64'h9, 5'd3, 0, 64'h3F};
    vecs[1]  = '{OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd4, 0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{OP_UMULH, 64'h8000_0000_0000_0000, 64'h4, 5'd5, 0, 64'h2};
    vecs[3]  = '{OP_SDIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 5'd6, 0, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[4]  = '{OP_UDIV,  64'd100, 64'd7, 5'd7, 0, 64'd14};
    vecs[5]  = '{OP_SDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 0,
                 64'h8000_0000_0000_0000};
    vecs[6]  = '{OP_UDIV,  64'd5, 64'd0, 5'd9, 0, 64'd0};
    vecs[7]  = '{3'b011,   64'd5, 64'd3, 5'd10, 0, 64'd0};
    vecs[8]  = '{OP_MUL,   64'd2, 64'd3, 5'd31, 0, 64'd6};
    vecs[9]  = '{OP_SMULH, 64'h8000_0000_0000_0000, 64'h2, 5'd11, 0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{OP_SDIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd12, 0, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[11] = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 0, 64'd1};
    vecs[12] = '{OP_SDIV,  64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 5'd14, 0, 64'd0};
    vecs[13] = '{OP_SMULH, 64'd3, 64'd5, 5'd15, 0, 64'd0};
    vecs[14] = '{OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 10,
                 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[15] = '{OP_SDIV,  64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 5'd17, 3, 64'd0};

    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    check("reset out_valid", 64'(bus.out_valid), 64'(0));
    check("reset out_data", bus.out_data, 64'(0));
    check("reset out_rd", 64'(bus.out_rd), 64'(0));
    check("reset out_write", 64'(bus.out_write), 64'(0));
    check("reset in_ready low", 64'(bus.in_ready), 64'(0));
    reset_n = 1'b1;
    #1;
    check("reset in_ready high", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Flush in the middle of CALC.
    bus.out_ready = 1'b1;
    start_op(OP_MUL, 64'd11, 64'd13, 5'd20);
    for (int i = 0; i < 20; i++) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush calc idle", 64'(bus.in_ready), 64'(1));
    seen_valid = 1'b0;
    seen_write = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      seen_valid |= bus.out_valid;
      seen_write |= bus.out_write;
    end
    check("flush calc no valid", 64'(seen_valid), 64'(0));
    check("flush calc no write", 64'(seen_write), 64'(0));

    // Flush beats a same-cycle accept.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    flush        = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    @(negedge clock);
    check("flush vs accept", 64'(bus.in_ready), 64'(1));

    // Flush beats a same-cycle out_ready in DONE.
    bus.out_ready = 1'b0;
    start_op(OP_MUL, 64'd2, 64'd3, 5'd4);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!bus.out_valid && cyc < 200);
    check("flush done latency", 64'(cyc), 64'(66));
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("flush done no write", 64'(bus.out_write), 64'(0));
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush done valid", 64'(bus.out_valid), 64'(0));
    check("flush done idle", 64'(bus.in_ready), 64'(1));

    // Reset in the middle of CALC, then a fresh op.
    run_op(vecs[0], "pre-reset");
    start_op(OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd21);
    for (int i = 0; i < 30; i++) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(bus.out_valid), 64'(0));
    check("midreset out_data", bus.out_data, 64'(0));
    check("midreset out_rd", 64'(bus.out_rd), 64'(0));
    check("midreset out_write", 64'(bus.out_write), 64'(0));
    check("midreset in_ready", 64'(bus.in_ready), 64'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_op(vecs[4], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
